// File: rtl/rcagb_serial_sub_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
interface rcagb_serial_sub_if #(
  parameter int unsigned G = 128
);
  logic         in_valid;
  logic         in_ready;
  logic [G-1:0] a;
  logic [G-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [G-1:0] diff;
  logic         borrow;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/rcagb_serial_sub.sv
// Digit-serial subtractor: diff = (a - b - bin) mod 2^G, one W-bit chunk per
// clock, LSB chunk first. Companion of the rcagb ripple-carry adder.
module rcagb_serial_sub #(
  parameter int unsigned G = 128,
  parameter int unsigned W = 8
) (
  input  logic               clk,
  input  logic               rst,
  rcagb_serial_sub_if.slave  bus,
  output logic               busy
);

  localparam int unsigned N  = G / W;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  // Operands are shifted right each RUN cycle so the live chunk is always at
  // the bottom; diff fills from the top so chunk 0 lands at bit 0 after N steps.
  logic [G-1:0]  a_q;
  logic [G-1:0]  b_q;
  logic [G-1:0]  diff_q;
  logic          br_q;
  logic          borrow_q;
  logic          out_valid_q;
  logic [KW-1:0] k_q;

  logic [W:0]    chunk_c;
  logic          last_c;

  // One chunk of subtraction at W+1 bits; the top bit is the borrow out.
  always_comb begin
    chunk_c = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]} - (W+1)'(br_q);
    last_c  = (k_q == KW'(N - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid)  state_next = RUN;
      RUN:  if (last_c)        state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Operand capture and per-chunk datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      k_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            br_q     <= bus.bin;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
          end
        end
        RUN: begin
          a_q    <= a_q >> W;
          b_q    <= b_q >> W;
          diff_q <= {chunk_c[W-1:0], diff_q[G-1:W]};
          br_q   <= chunk_c[W];
          k_q    <= k_q + KW'(1);
          if (last_c) begin
            borrow_q <= chunk_c[W];
          end
        end
        default: ;
      endcase
    end
  end

  // Result-valid flag, registered alongside the state it mirrors.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_next == DONE);
    end
  end

  // in_ready is suppressed during reset so no operand is offered as accepted.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign busy          = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_rcagb_serial_sub.sv
// Self-checking bench for rcagb_serial_sub with an arithmetic reference model.
module tb_rcagb_serial_sub;

  localparam int unsigned G = 128;
  localparam int unsigned W = 8;
  localparam int unsigned N = G / W;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  rcagb_serial_sub_if #(.G(G)) bus ();

  rcagb_serial_sub #(.G(G), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cycle++;
    #1;
  endtask

  function automatic logic [G-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: plain unsigned subtraction at G+1 bits; top bit is the borrow.
  function automatic logic [G:0] ref_sub(input logic [G-1:0] x, input logic [G-1:0] y,
                                         input logic c);
    return {1'b0, x} - {1'b0, y} - (G+1)'(c);
  endfunction

  // Offer one operand set, then wait (bounded) for out_valid.
  task automatic run_op(input logic [G-1:0] x, input logic [G-1:0] y, input logic c,
                        output logic [G-1:0] d, output logic bo, output int lat,
                        output int acc);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    bus.a = x; bus.b = y; bus.bin = c; bus.in_valid = 1'b1;
    acc = cycle;
    tick();
    bus.in_valid = 1'b0;
    bus.a = rnd(); bus.b = rnd(); bus.bin = 1'($urandom_range(0, 1));
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    d  = bus.diff;
    bo = bus.borrow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.a = 128'd5; bus.b = 128'd3; bus.bin = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.diff !== '0) begin errors++; $display("FAIL reset_diff: got %h expected 0", bus.diff); end
    checks++; if (bus.borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", bus.borrow); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_wins_busy: got %b expected 0", busy); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [G-1:0] d; logic bo; int lat; int acc;
    run_op(128'd100, 128'd37, 1'b0, d, bo, lat, acc);
    checks++; if (d !== 128'd63) begin errors++; $display("FAIL basic_diff: got %h expected %h", d, 128'd63); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b expected 0", bo); end
    checks++; if (lat !== int'(N)) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, N); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_idle: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_wrap();
    logic [G-1:0] d; logic bo; int lat; int acc;
    logic [G:0] s;
    run_op(128'd0, 128'd1, 1'b0, d, bo, lat, acc);
    checks++; if (d !== {G{1'b1}}) begin errors++; $display("FAIL wrap_diff: got %h expected all ones", d); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL wrap_borrow: got %b expected 1", bo); end
    s = {1'b0, d} + (G+1)'(1) + (G+1)'(0);
    checks++; if (s !== {1'b1, {G{1'b0}}}) begin errors++; $display("FAIL wrap_roundtrip: got %h expected carry=1 sum=0", s); end
    tick();
  endtask

  task automatic test_borrow_in();
    logic [G-1:0] av [3];
    logic [G-1:0] bv [3];
    logic         cv [3];
    logic [G-1:0] dv [3];
    logic         ov [3];
    logic [G-1:0] d; logic bo; int lat; int acc;
    av[0] = 128'd5;     bv[0] = 128'd5; cv[0] = 1'b1; dv[0] = {G{1'b1}};             ov[0] = 1'b1;
    av[1] = 128'd5;     bv[1] = 128'd5; cv[1] = 1'b0; dv[1] = '0;                    ov[1] = 1'b0;
    av[2] = {G{1'b1}};  bv[2] = '0;     cv[2] = 1'b1; dv[2] = {{(G-1){1'b1}}, 1'b0}; ov[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], cv[i], d, bo, lat, acc);
      checks++; if (d !== dv[i]) begin errors++; $display("FAIL borrow_in_diff[%0d]: got %h expected %h", i, d, dv[i]); end
      checks++; if (bo !== ov[i]) begin errors++; $display("FAIL borrow_in_borrow[%0d]: got %b expected %b", i, bo, ov[i]); end
      tick();
    end
  endtask

  task automatic test_cross_chunk();
    logic [G-1:0] d; logic bo; int lat; int acc;
    logic [G-1:0] x; logic [G-1:0] e;
    x = G'(1) << 64;
    e = x - G'(1);
    run_op(x, 128'd1, 1'b0, d, bo, lat, acc);
    checks++; if (d !== e) begin errors++; $display("FAIL cross_chunk_diff: got %h expected %h", d, e); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL cross_chunk_borrow: got %b expected 0", bo); end
    tick();
  endtask

  task automatic test_random();
    logic [G-1:0] d; logic bo; int lat; int acc;
    logic [G-1:0] x; logic [G-1:0] y; logic c; logic [G:0] e; logic [G:0] s;
    for (int i = 0; i < 24; i++) begin
      x = rnd();
      y = ($urandom_range(0, 3) == 0) ? x : rnd();
      if ($urandom_range(0, 5) == 0) y = {G{1'b1}};
      c = 1'($urandom_range(0, 1));
      e = ref_sub(x, y, c);
      run_op(x, y, c, d, bo, lat, acc);
      checks++; if ({bo, d} !== e) begin errors++; $display("FAIL random_result[%0d]: got %b_%h expected %b_%h", i, bo, d, e[G], e[G-1:0]); end
      checks++; if (lat !== int'(N)) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, N); end
      s = {1'b0, d} + {1'b0, y} + (G+1)'(c);
      checks++; if (s !== {bo, x}) begin errors++; $display("FAIL random_roundtrip[%0d]: got %h expected %h", i, s, {bo, x}); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [G-1:0] d; logic bo; int lat; int acc; int prev;
    logic [G-1:0] x; logic [G-1:0] y; logic c; logic [G:0] e;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      x = rnd(); y = rnd(); c = 1'($urandom_range(0, 1));
      e = ref_sub(x, y, c);
      run_op(x, y, c, d, bo, lat, acc);
      checks++; if ({bo, d} !== e) begin errors++; $display("FAIL b2b_result[%0d]: got %b_%h expected %b_%h", i, bo, d, e[G], e[G-1:0]); end
      if (i > 0) begin
        checks++; if (acc - prev !== int'(N) + 2) begin errors++; $display("FAIL b2b_throughput[%0d]: got %0d expected %0d", i, acc - prev, N + 2); end
      end
      prev = acc;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [G-1:0] d; logic bo; int lat; int acc;
    logic [G-1:0] x2; logic [G-1:0] y2; logic c2; logic [G:0] e1; logic [G:0] e2;
    logic [G-1:0] x1; logic [G-1:0] y1; logic c1;
    x1 = rnd(); y1 = rnd(); c1 = 1'($urandom_range(0, 1));
    x2 = rnd(); y2 = rnd(); c2 = 1'($urandom_range(0, 1));
    e1 = ref_sub(x1, y1, c1);
    e2 = ref_sub(x2, y2, c2);
    bus.out_ready = 1'b0;
    run_op(x1, y1, c1, d, bo, lat, acc);
    checks++; if ({bo, d} !== e1) begin errors++; $display("FAIL bp_first_result: got %b_%h expected %b_%h", bo, d, e1[G], e1[G-1:0]); end
    bus.a = x2; bus.b = y2; bus.bin = c2; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if ({bus.borrow, bus.diff} !== e1) begin errors++; $display("FAIL bp_hold_data[%0d]: got %b_%h expected %b_%h", i, bus.borrow, bus.diff, e1[G], e1[G-1:0]); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed: got %b expected 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_overlap: got %b expected 0", busy); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_accept_next: got %b expected 1", busy); end
    bus.in_valid = 1'b0;
    bus.a = rnd(); bus.b = rnd();
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    checks++; if ({bus.borrow, bus.diff} !== e2) begin errors++; $display("FAIL bp_second_result: got %b_%h expected %b_%h", bus.borrow, bus.diff, e2[G], e2[G-1:0]); end
    checks++; if (lat !== int'(N)) begin errors++; $display("FAIL bp_second_latency: got %0d expected %0d", lat, N); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [G-1:0] d; logic bo; int lat; int acc;
    bus.a = rnd(); bus.b = rnd(); bus.bin = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i < 7; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_run_valid[%0d]: got %b expected 0", i, bus.out_valid); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.diff !== '0) begin errors++; $display("FAIL mid_rst_diff: got %h expected 0", bus.diff); end
    checks++; if (bus.borrow !== 1'b0) begin errors++; $display("FAIL mid_rst_borrow: got %b expected 0", bus.borrow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 1", bus.in_ready); end
    run_op(128'd10, 128'd3, 1'b0, d, bo, lat, acc);
    checks++; if (d !== 128'd7) begin errors++; $display("FAIL mid_rst_fresh_diff: got %h expected 7", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL mid_rst_fresh_borrow: got %b expected 0", bo); end
    checks++; if (lat !== int'(N)) begin errors++; $display("FAIL mid_rst_fresh_latency: got %0d expected %0d", lat, N); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_borrow_in();
    test_cross_chunk();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
